// File: rtl/btn_pkg.sv
// Shared types and helpers for the button press decoder.
// The state enum is common to all channels; the width helper sizes the tick counter.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        HELD
    } btn_state_t;

    // Smallest unsigned width that can hold the larger of the two tick thresholds.
    function automatic int cnt_width(input int long_ticks, input int repeat_ticks);
        int m;
        m = (long_ticks > repeat_ticks) ? long_ticks : repeat_ticks;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/btn_press_fsm.sv
// One button channel: classifies a debounced level into short, long and repeat pulses.
// A channel only arms after it has seen the button released, so a button held through reset stays silent.
module btn_press_fsm
    import btn_pkg::*;
#(
    parameter int LONG_PRESS_TICKS = 500,
    parameter int REPEAT_TICKS     = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic btn,
    output logic pressed,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int CW = cnt_width(LONG_PRESS_TICKS, REPEAT_TICKS);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PRESS_TICKS - 1);
    localparam logic [CW-1:0] REP_LAST  = (REPEAT_TICKS > 0) ? CW'(REPEAT_TICKS - 1) : '0;

    btn_state_t    state;
    logic [CW-1:0] cnt;
    logic          armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            armed        <= 1'b0;
            pressed      <= 1'b0;
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle so each one lasts exactly one clk; all state uses <=.
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            if (!btn) begin
                armed <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (btn && armed) begin
                        state   <= PRESSED;
                        cnt     <= '0;
                        pressed <= 1'b1;
                    end
                end

                PRESSED: begin
                    if (!btn) begin
                        state       <= IDLE;
                        pressed     <= 1'b0;
                        short_pulse <= 1'b1;
                    end else if (en) begin
                        if (cnt == LONG_LAST) begin
                            state      <= HELD;
                            cnt        <= '0;
                            long_pulse <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end

                HELD: begin
                    // Release wins over a coincident tick, so no repeat on the way out.
                    if (!btn) begin
                        state   <= IDLE;
                        pressed <= 1'b0;
                    end else if (en && (REPEAT_TICKS > 0)) begin
                        if (cnt == REP_LAST) begin
                            cnt          <= '0;
                            repeat_pulse <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    pressed <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_press_decoder.sv
// Multi-channel button event decoder: DW independent copies of the single-channel FSM.
// All channels share the 500 Hz enable tick; there is no cross-channel logic.
module btn_press_decoder
    import btn_pkg::*;
#(
    parameter int DW               = 2,
    parameter int LONG_PRESS_TICKS = 500,
    parameter int REPEAT_TICKS     = 100
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [DW-1:0] btn_i,
    output logic [DW-1:0] pressed_o,
    output logic [DW-1:0] short_o,
    output logic [DW-1:0] long_o,
    output logic [DW-1:0] repeat_o
);

    for (genvar g = 0; g < DW; g++) begin : g_ch
        btn_press_fsm #(
            .LONG_PRESS_TICKS(LONG_PRESS_TICKS),
            .REPEAT_TICKS    (REPEAT_TICKS)
        ) u_fsm (
            .clk         (clk),
            .rst         (rst),
            .en          (en_i),
            .btn         (btn_i[g]),
            .pressed     (pressed_o[g]),
            .short_pulse (short_o[g]),
            .long_pulse  (long_o[g]),
            .repeat_pulse(repeat_o[g])
        );
    end

endmodule

// File: tb/tb_btn_press_decoder.sv
// Scoreboard bench for btn_press_decoder: a tick-counting reference model queues expected outputs per cycle,
// a monitor pops and compares them, and per-scenario event counts are checked against fixed numbers.
module tb_btn_press_decoder;

    localparam int DW = 2;
    localparam int L  = 4;
    localparam int R  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en_i = 1'b0;
    logic [DW-1:0] btn_i = '0;
    logic [DW-1:0] pressed_o, short_o, long_o, repeat_o;

    btn_press_decoder #(
        .DW              (DW),
        .LONG_PRESS_TICKS(L),
        .REPEAT_TICKS    (R)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en_i     (en_i),
        .btn_i    (btn_i),
        .pressed_o(pressed_o),
        .short_o  (short_o),
        .long_o   (long_o),
        .repeat_o (repeat_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] prs;
        logic [DW-1:0] shr;
        logic [DW-1:0] lng;
        logic [DW-1:0] rpt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;
    int   phase = 0;

    bit m_armed[DW];
    bit m_active[DW];
    int m_ticks[DW];
    int cnt_short[DW], cnt_long[DW], cnt_rpt[DW], cnt_prs[DW];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one clk cycle of stimulus (en every 4th cycle) and queue the model's expected outputs.
    task automatic drive(input logic r, input logic [DW-1:0] b);
        exp_t e;
        logic t;
        bit   was;
        @(negedge clk);
        t = (phase % 4 == 3);
        phase++;
        rst   = r;
        btn_i = b;
        en_i  = t;
        e = '0;
        for (int c = 0; c < DW; c++) begin
            if (r) begin
                m_armed[c]  = 1'b0;
                m_active[c] = 1'b0;
                m_ticks[c]  = 0;
            end else begin
                was = m_armed[c];
                if (!b[c]) m_armed[c] = 1'b1;
                if (!m_active[c]) begin
                    if (b[c] && was) begin
                        m_active[c] = 1'b1;
                        m_ticks[c]  = 0;
                    end
                end else if (!b[c]) begin
                    if (m_ticks[c] < L) e.shr[c] = 1'b1;
                    m_active[c] = 1'b0;
                end else if (t) begin
                    m_ticks[c]++;
                    if (m_ticks[c] == L) e.lng[c] = 1'b1;
                    else if (m_ticks[c] > L && R > 0 && ((m_ticks[c] - L) % R) == 0) e.rpt[c] = 1'b1;
                end
            end
            e.prs[c] = m_active[c];
        end
        sb_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("pressed_o", 32'(pressed_o), 32'(mon_e.prs));
            check("short_o",   32'(short_o),   32'(mon_e.shr));
            check("long_o",    32'(long_o),    32'(mon_e.lng));
            check("repeat_o",  32'(repeat_o),  32'(mon_e.rpt));
            for (int c = 0; c < DW; c++) begin
                cnt_short[c] += int'(short_o[c]);
                cnt_long[c]  += int'(long_o[c]);
                cnt_rpt[c]   += int'(repeat_o[c]);
                cnt_prs[c]   += int'(pressed_o[c]);
            end
        end
    end

    task automatic run(input int n, input logic [DW-1:0] b);
        repeat (n) drive(1'b0, b);
    endtask

    task automatic align();
        while (phase % 4 != 0) drive(1'b0, '0);
    endtask

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        run(2, '0);
        sync();
    endtask

    task automatic clear_counts();
        for (int c = 0; c < DW; c++) begin
            cnt_short[c] = 0;
            cnt_long[c]  = 0;
            cnt_rpt[c]   = 0;
            cnt_prs[c]   = 0;
        end
    endtask

    initial begin
        clear_counts();
        repeat (3) drive(1'b1, '0);
        run(2, '0);

        // Short press: 6 cycles, one tick.
        align(); clear_counts();
        run(6, 2'b01); run(1, 2'b00); settle();
        check("s1_short0", cnt_short[0], 1);
        check("s1_long0",  cnt_long[0],  0);
        check("s1_rpt0",   cnt_rpt[0],   0);
        check("s1_prs0",   cnt_prs[0],   6);

        // Long press with repeat: 40 cycles covers 10 ticks -> long at 4, repeats at 6, 8, 10.
        align(); clear_counts();
        run(40, 2'b10); run(1, 2'b00); settle();
        check("s2_short1", cnt_short[1], 0);
        check("s2_long1",  cnt_long[1],  1);
        check("s2_rpt1",   cnt_rpt[1],   3);
        check("s2_prs1",   cnt_prs[1],   40);

        // Release on the same cycle as the 4th tick.
        align(); clear_counts();
        run(15, 2'b01); drive(1'b0, 2'b00); settle();
        check("s3_short0", cnt_short[0], 1);
        check("s3_long0",  cnt_long[0],  0);

        // Held through reset: silent until released and pressed again.
        clear_counts();
        repeat (3) drive(1'b1, 2'b01);
        run(30, 2'b01); sync();
        check("s4_events0", cnt_short[0] + cnt_long[0] + cnt_rpt[0], 0);
        check("s4_prs0",    cnt_prs[0], 0);
        run(1, 2'b00); run(2, 2'b01); run(1, 2'b00); settle();
        check("s4_short0", cnt_short[0], 1);
        check("s4_prs0b",  cnt_prs[0],   2);

        // Reset mid-hold: 5 ticks reaches HELD, reset clears silently.
        align(); clear_counts();
        run(20, 2'b01); drive(1'b1, 2'b01); run(1, 2'b00); sync();
        check("s5_long0",  cnt_long[0],  1);
        check("s5_rpt0",   cnt_rpt[0],   0);
        check("s5_short0", cnt_short[0], 0);
        align(); clear_counts();
        run(6, 2'b01); run(1, 2'b00); settle();
        check("s5_short0b", cnt_short[0], 1);
        check("s5_prs0b",   cnt_prs[0],   6);

        // Independent channels: btn0 released after tick 2, btn1 after tick 6.
        align(); clear_counts();
        run(8, 2'b11); run(16, 2'b10); run(1, 2'b00); settle();
        check("s6_short0", cnt_short[0], 1);
        check("s6_long0",  cnt_long[0],  0);
        check("s6_short1", cnt_short[1], 0);
        check("s6_long1",  cnt_long[1],  1);
        check("s6_rpt1",   cnt_rpt[1],   1);
        check("s6_rpt0",   cnt_rpt[0],   0);

        check("sb_empty", 32'(sb_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/btn_press_decoder.md
# btn_press_decoder

Classifies debounced button levels into discrete user events: short press, long press and auto-repeat. It sits directly downstream of the CmodS7 button debounce stage. It consumes the debounced `btn_o` levels and the same 500 Hz enable tick, and drives one-cycle event pulses to the control logic. Each channel is independent and identical.

## Interface
Parameters:
- `DW`, default 2: number of button channels.
- `LONG_PRESS_TICKS`, default 500: en ticks of continuous hold before a long press fires (1 s at 500 Hz). Must be ≥ 2.
- `REPEAT_TICKS`, default 100: en ticks between auto-repeat pulses after a long press. 0 disables repeat.

Ports:
- `clk`  in  1: system clock; the only clock in the block.
- `rst`  in  1: reset, synchronous, active-high.
- `en_i`  in  1: one-`clk` enable tick, 500 Hz, from the shared enable generator.
- `btn_i`  in  DW: debounced button levels, 1 = pressed.
- `pressed_o`  out  DW: level, high while the channel is in PRESSED or HELD.
- `short_o`  out  DW: one-cycle pulse on release before the long threshold.
- `long_o`  out  DW: one-cycle pulse when the hold reaches `LONG_PRESS_TICKS`.
- `repeat_o`  out  DW: one-cycle pulse every `REPEAT_TICKS` while in HELD.

## Operation
Each channel has a state (IDLE, PRESSED, HELD), a tick counter and an `armed` flag.
- **Arming:** `armed` clears on reset and sets on the first cycle `btn_i` is sampled 0. While unarmed the channel stays in IDLE. A button held through reset therefore produces no events until it is released and pressed again.
- **IDLE:**
  - `btn_i`=1 and armed → PRESSED, counter := 0.
- **PRESSED:**
  - `btn_i`=0 → IDLE, pulse `short_o`.
  - Otherwise, on `en_i`, counter++.
  - When counter reaches `LONG_PRESS_TICKS`-1 and `en_i` is high → HELD, pulse `long_o`, counter := 0.
- **HELD:**
  - `btn_i`=0 → IDLE. No pulse on release.
  - Otherwise, on `en_i`, counter++.
  - When counter reaches `REPEAT_TICKS`-1 and `en_i` is high → pulse `repeat_o`, counter := 0, remain in HELD.
  - If `REPEAT_TICKS`=0, the counter holds and no repeat pulses are produced.
- **Priority:** release beats tick. If `btn_i`=0 in the same cycle a threshold tick arrives:
  - in PRESSED, `short_o` fires and `long_o` does not;
  - in HELD, `repeat_o` does not fire.
- **Counter width:** `$clog2(max(LONG_PRESS_TICKS, REPEAT_TICKS)+1)`, unsigned. The counter never wraps because it is cleared at each threshold.
- `btn_i` is evaluated every `clk` cycle, not only on ticks. Press duration is measured in ticks, so resolution is ±1 tick.

## Timing
- **Reset:** every output is 0, every state is IDLE, every counter is 0, every `armed` is 0. Reset takes priority over all other inputs; asserting `rst` mid-hold ends the hold silently with no pulse.
- **Registered outputs:** all outputs are registered.
  - An event pulse is high for exactly one `clk` cycle, starting the cycle after the edge on which the triggering `btn_i`/`en_i` condition was sampled.
  - `pressed_o` rises one cycle after `btn_i` is sampled high in IDLE. It falls one cycle after `btn_i` is sampled low.
- **Minimum press:** a press lasting one `clk` cycle with no intervening tick still yields `short_o`.
- **Pulse exclusivity:** at most one of `short_o`, `long_o`, `repeat_o` pulses per channel per cycle.
- **Back-to-back presses:** release in cycle N and press in cycle N+1 is legal. The second press starts a fresh PRESSED with counter 0.

## Structure
- **Package `btn_pkg`:**
  - `btn_state_t` enum {IDLE, PRESSED, HELD};
  - a helper function for the counter width.
- **Sub-module `btn_press_fsm`:** single-channel FSM plus counter plus `armed` flag. `btn_press_decoder` instantiates it `DW` times in a generate loop, sharing `en_i`.
- No cross-channel logic; no combinational path from any input to any output.

## Test plan
All scenarios use `LONG_PRESS_TICKS`=4, `REPEAT_TICKS`=2, and `en_i` every 4 `clk` cycles.
1. **Short press:** hold btn[0] for 6 cycles (1 tick), then release → one `short_o[0]` pulse 1 cycle after release. `long_o` and `repeat_o` stay 0. `pressed_o[0]` high for 6 cycles.
2. **Long press with repeat:** hold btn[1] for 40 cycles.
   - `long_o[1]` pulses on the 4th tick.
   - `repeat_o[1]` pulses on every 2nd tick after that.
   - Release → no `short_o`, `pressed_o[1]` falls 1 cycle later.
3. **Release coincident with threshold:** release btn[0] in the same cycle as the 4th tick → `short_o[0]` only, no `long_o[0]`.
4. **Held through reset:** hold btn[0]=1 across `rst` deassertion for 30 cycles → all outputs 0. Release, then press 2 cycles → `short_o[0]`.
5. **Reset mid-hold:** assert `rst` during HELD → all outputs 0 on the next cycle, no pulses. After `rst` drops with btn low, a new press behaves as in scenario 1.
6. **Independent channels:** press both channels, release btn[0] at tick 2 and btn[1] at tick 6 → `short_o[0]`, then `long_o[1]` and `repeat_o[1]`. Neither channel affects the other.
